// File: rtl/ascon_host_if.sv
// ascon_host_if
// Byte-stream host front end for an Ascon core. The host sends a command byte.
// Some commands are followed by 16 payload bytes. The block answers read and
// status commands with response bytes on the out channel.
//
// Command byte layout:
//   [7:6] opcode: 00 write, 01 read, 10 start, 11 status
//   [2:0] argument: register index for write/read, mode for start
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_data/in_ready       host -> block byte channel
//   out_valid/out_data/out_ready    block -> host byte channel
//   reg0_128b..reg2_128b            key/data registers driven to the core
//   operation_mode/operation_ready  core mode and one-cycle start pulse
//   reg_128b_wrback_*               core result writeback into reg0..reg2
//   busy                            core operation in progress
module ascon_host_if (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready,
  output logic [127:0] reg0_128b,
  output logic [127:0] reg1_128b,
  output logic [127:0] reg2_128b,
  output logic [2:0]   operation_mode,
  output logic         operation_ready,
  input  logic         reg_128b_wrback_en,
  input  logic [1:0]   reg_128b_wrback_sel,
  input  logic [127:0] reg_128b_wrback_val,
  output logic         busy
);

  typedef enum logic [1:0] {CMD, WDATA, RDATA, STAT} state_t;

  state_t       state;
  logic [3:0]   count;
  logic [2:0]   target;
  logic         write_ok;

  logic         in_fire;
  logic         out_fire;
  logic [1:0]   opcode;
  logic [2:0]   arg;
  logic [127:0] cmd_src;
  logic [127:0] rd_src;
  logic [3:0]   next_cnt;
  logic [7:0]   next_byte;
  logic         unused_cmd_bits;

  assign in_ready  = (state == CMD) || (state == WDATA);
  assign out_valid = (state == RDATA) || (state == STAT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign opcode    = in_data[7:6];
  assign arg       = in_data[2:0];
  assign unused_cmd_bits = ^in_data[5:3];

  // Register sources for read responses. Indices 3..7 read as all zeros.
  // The byte for the next transfer is byte (15 - next_cnt), which is ~next_cnt.
  always_comb begin
    cmd_src = '0;
    case (arg)
      3'd0:    cmd_src = reg0_128b;
      3'd1:    cmd_src = reg1_128b;
      3'd2:    cmd_src = reg2_128b;
      default: cmd_src = '0;
    endcase
    rd_src = '0;
    case (target)
      3'd0:    rd_src = reg0_128b;
      3'd1:    rd_src = reg1_128b;
      3'd2:    rd_src = reg2_128b;
      default: rd_src = '0;
    endcase
    next_cnt  = count + 4'd1;
    next_byte = 8'(rd_src >> {~next_cnt, 3'b000});
  end

  // Command FSM, register file and start/busy control.
  // out_data is registered so it stays stable during back-pressure even if a
  // writeback changes the register being read.
  // A tag writeback clears busy before the FSM is evaluated, so a start in the
  // same cycle leaves busy set. Core writeback is assigned last, so it
  // overrides a host payload byte aimed at the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= CMD;
      count           <= 4'd0;
      target          <= 3'd0;
      write_ok        <= 1'b0;
      out_data        <= 8'h00;
      reg0_128b       <= '0;
      reg1_128b       <= '0;
      reg2_128b       <= '0;
      operation_mode  <= 3'd0;
      operation_ready <= 1'b0;
      busy            <= 1'b0;
    end else begin
      operation_ready <= 1'b0;
      if (reg_128b_wrback_en && reg_128b_wrback_sel == 2'd2) begin
        busy <= 1'b0;
      end
      case (state)
        CMD: begin
          if (in_fire) begin
            case (opcode)
              2'b00: begin
                state    <= WDATA;
                count    <= 4'd0;
                target   <= arg;
                write_ok <= !busy && (arg < 3'd3);
              end
              2'b01: begin
                state    <= RDATA;
                count    <= 4'd0;
                target   <= arg;
                out_data <= cmd_src[127:120];
              end
              2'b10: begin
                if (!busy && arg >= 3'd1 && arg <= 3'd5) begin
                  operation_mode  <= arg;
                  operation_ready <= 1'b1;
                  busy            <= 1'b1;
                end
              end
              default: begin
                state    <= STAT;
                out_data <= {busy, 7'b0};
              end
            endcase
          end
        end
        WDATA: begin
          if (in_fire) begin
            if (write_ok) begin
              case (target[1:0])
                2'd0:    reg0_128b <= {reg0_128b[119:0], in_data};
                2'd1:    reg1_128b <= {reg1_128b[119:0], in_data};
                default: reg2_128b <= {reg2_128b[119:0], in_data};
              endcase
            end
            count <= next_cnt;
            if (count == 4'd15) begin
              state <= CMD;
            end
          end
        end
        RDATA: begin
          if (out_fire) begin
            count <= next_cnt;
            if (count == 4'd15) begin
              state    <= CMD;
              out_data <= 8'h00;
            end else begin
              out_data <= next_byte;
            end
          end
        end
        STAT: begin
          if (out_fire) begin
            state    <= CMD;
            out_data <= 8'h00;
          end
        end
        default: state <= CMD;
      endcase
      if (reg_128b_wrback_en) begin
        case (reg_128b_wrback_sel)
          2'd0:    reg0_128b <= reg_128b_wrback_val;
          2'd1:    reg1_128b <= reg_128b_wrback_val;
          2'd2:    reg2_128b <= reg_128b_wrback_val;
          default: ;
        endcase
      end
    end
  end

endmodule
